// File: rtl/button_event_decoder.sv
// Turns a debounced button level into click / double-click / long-press pulses,
// plus auto-repeat ticks and a held level while a long press persists.
module button_event_decoder #(
   parameter int unsigned LONG_TIME   = 50000,
   parameter int unsigned DOUBLE_GAP  = 20000,
   parameter int unsigned REPEAT_TIME = 10000,
   parameter int unsigned CNT_LEN     = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_level,
   output logic       click,
   output logic       double_click,
   output logic       long_press,
   output logic       repeat_tick,
   output logic       held,
   output logic [2:0] dbg_state_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_PRESS1 = 3'd1,
      S_GAP    = 3'd2,
      S_PRESS2 = 3'd3,
      S_LONG   = 3'd4
   } state_e;

   localparam logic [CNT_LEN-1:0] LONG_LAST   = CNT_LEN'(LONG_TIME - 1);
   localparam logic [CNT_LEN-1:0] GAP_LAST    = CNT_LEN'(DOUBLE_GAP - 1);
   localparam logic [CNT_LEN-1:0] REPEAT_LAST = CNT_LEN'(REPEAT_TIME - 1);

   state_e               state_q, state_d;
   logic [CNT_LEN-1:0]   cnt_q, cnt_d;
   logic                 click_q, click_d;
   logic                 double_q, double_d;
   logic                 long_q, long_d;
   logic                 repeat_q, repeat_d;
   logic                 held_q, held_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         click_q  <= 1'b0;
         double_q <= 1'b0;
         long_q   <= 1'b0;
         repeat_q <= 1'b0;
         held_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         click_q  <= click_d;
         double_q <= double_d;
         long_q   <= long_d;
         repeat_q <= repeat_d;
         held_q   <= held_d;
      end
   end

   // A button edge is always tested before counter expiry, so it wins ties.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + CNT_LEN'(1);
      click_d  = 1'b0;
      double_d = 1'b0;
      long_d   = 1'b0;
      repeat_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (btn_level) state_d = S_PRESS1;
         end
         S_PRESS1: begin
            if (!btn_level) begin
               state_d = S_GAP;
               cnt_d   = '0;
            end else if (cnt_q == LONG_LAST) begin
               state_d = S_LONG;
               cnt_d   = '0;
               long_d  = 1'b1;
            end
         end
         S_GAP: begin
            if (btn_level) begin
               state_d = S_PRESS2;
               cnt_d   = '0;
            end else if (cnt_q == GAP_LAST) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               click_d = 1'b1;
            end
         end
         S_PRESS2: begin
            if (!btn_level) begin
               state_d  = S_IDLE;
               cnt_d    = '0;
               double_d = 1'b1;
            end else if (cnt_q == LONG_LAST) begin
               state_d = S_LONG;
               cnt_d   = '0;
               long_d  = 1'b1;
            end
         end
         S_LONG: begin
            if (!btn_level) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == REPEAT_LAST) begin
               cnt_d    = '0;
               repeat_d = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
      held_d = (state_d == S_LONG);
   end

   assign click        = click_q;
   assign double_click = double_q;
   assign long_press   = long_q;
   assign repeat_tick  = repeat_q;
   assign held         = held_q;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Randomized and directed gestures checked against a run-length gesture model
// through an expected-pulse queue consumed by an independent monitor.
module tb_button_event_decoder;
  localparam int LT = 8;
  localparam int DG = 4;
  localparam int RT = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_level = 1'b0;
  logic       click, double_click, long_press, repeat_tick, held;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];
  logic exp_held = 1'b0;

  // gesture model: presses in current gesture, high/low run lengths, long flag
  int m_presses = 0;
  int m_hi = 0;
  int m_lo = 0;
  bit m_long = 1'b0;

  button_event_decoder #(
    .LONG_TIME(LT), .DOUBLE_GAP(DG), .REPEAT_TIME(RT), .CNT_LEN(20)
  ) dut (
    .clk(clk), .reset(reset), .btn_level(btn_level),
    .click(click), .double_click(double_click), .long_press(long_press),
    .repeat_tick(repeat_tick), .held(held), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic model_clear();
    m_presses = 0;
    m_hi = 0;
    m_lo = 0;
    m_long = 1'b0;
    exp_held = 1'b0;
  endtask

  // pulse bits: 0 click, 1 double_click, 2 long_press, 3 repeat_tick
  task automatic model_step(input logic b, input int edge_no);
    logic [3:0] p;
    p = 4'b0;
    if (b) begin
      if (m_long) begin
        m_hi++;
        if ((m_hi - (LT + 1)) % RT == 0) p = 4'b1000;
      end else begin
        if (m_presses == 0) begin
          m_presses = 1;
          m_hi = 0;
        end else if (m_lo > 0) begin
          m_presses = 2;
          m_hi = 0;
          m_lo = 0;
        end
        m_hi++;
        if (m_hi == LT + 1) begin
          m_long = 1'b1;
          p = 4'b0100;
        end
      end
    end else begin
      if (m_long) begin
        m_long = 1'b0;
        m_presses = 0;
        m_hi = 0;
      end else if (m_presses == 2) begin
        p = 4'b0010;
        m_presses = 0;
      end else if (m_presses == 1) begin
        m_lo++;
        if (m_lo == DG + 1) begin
          p = 4'b0001;
          m_presses = 0;
          m_lo = 0;
        end
      end
    end
    exp_held = m_long;
    if (p != 4'b0) exp_q.push_back({edge_no[27:0], p});
  endtask

  task automatic step(input logic b);
    @(negedge clk);
    #1;
    btn_level = b;
    model_step(b, cyc + 1);
  endtask

  task automatic hold(input logic b, input int n);
    repeat (n) step(b);
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({click, double_click, long_press, repeat_tick, held} !== 5'b0) begin
      errors++;
      $display("FAIL %s: outputs=%b required=00000", name,
               {click, double_click, long_press, repeat_tick, held});
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    check_all_zero("async_reset_outputs");
    btn_level = 1'b0;
    repeat (n) @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  // monitor
  initial begin
    logic [3:0]  pulses;
    logic [31:0] got, exp;
    forever begin
      @(negedge clk);
      if (!reset) begin
        pulses = {repeat_tick, long_press, double_click, click};
        checks++;
        assert ($onehot0(pulses)) else begin
          errors++;
          $display("FAIL pulse_exclusive: cycle %0d pulses=%b required onehot0", cyc, pulses);
        end
        while (exp_q.size() > 0 && exp_q[0][31:4] < cyc[27:0]) begin
          checks++;
          errors++;
          $display("FAIL missed_pulse: expected %h never seen (now cycle %0d)", exp_q[0], cyc);
          void'(exp_q.pop_front());
        end
        if (pulses != 4'b0 || (exp_q.size() > 0 && exp_q[0][31:4] == cyc[27:0])) begin
          got = {cyc[27:0], pulses};
          if (exp_q.size() > 0 && exp_q[0][31:4] == cyc[27:0]) exp = exp_q.pop_front();
          else exp = {cyc[27:0], 4'b0};
          checks++;
          if (got !== exp) begin
            errors++;
            $display("FAIL pulse: cycle %0d got pulses=%b required=%b", cyc, got[3:0], exp[3:0]);
          end
        end
        checks++;
        if (held !== exp_held) begin
          errors++;
          $display("FAIL held: cycle %0d got=%b required=%b", cyc, held, exp_held);
        end
      end
    end
  end

  // stimulus
  initial begin
    logic b;
    int len;
    #1;
    check_all_zero("reset_outputs");
    checks++;
    if (dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: got=%0d required=0", dbg_state);
    end
    repeat (3) @(negedge clk);
    #1;
    reset = 1'b0;

    hold(1, 3); hold(0, 8);                              // single click
    hold(1, 2); hold(0, 2); hold(1, 2); hold(0, 8);      // double click
    hold(1, 20); hold(0, 8);                             // long press + repeat
    hold(1, 2); hold(0, DG - 1); hold(1, 2); hold(0, 8); // gap boundary -> double
    hold(1, 2); hold(0, DG); hold(1, 2); hold(0, 8);
    hold(1, 2); hold(0, DG + 1); hold(1, 2); hold(0, 10); // gap too long -> click, then click
    hold(1, 4); do_reset(2); hold(0, 6);                 // reset mid-PRESS1
    hold(1, 12); do_reset(2); hold(0, 6);                // reset mid-LONG
    hold(1, 2); hold(0, 2); hold(1, 9); hold(0, 6);      // long second press

    b = 1'b1;
    for (int i = 0; i < 120; i++) begin
      case ($urandom_range(0, 3))
        0: len = $urandom_range(1, 12);
        1: len = $urandom_range(DG - 1, DG + 2);
        2: len = $urandom_range(LT - 1, LT + 2);
        default: len = $urandom_range(LT + 1, LT + 3 * RT + 2);
      endcase
      hold(b, len);
      b = ~b;
      if ($urandom_range(0, 14) == 0) begin
        do_reset($urandom_range(1, 3));
        b = 1'b1;
      end
    end
    hold(0, 12);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected: %0d pulses pending, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
